cvxif_copro_router: RTL and testbench

Parametrised CV-X-IF fabric between the core's coprocessor interface and up to four coprocessors. It is the successor of the single-coprocessor hookup. Issue requests are steered by custom opcode, and an in-flight ID ownership table routes commits to the coprocessor that accepted each instruction. Results from all coprocessors are merged through a round-robin arbiter and a registered output stage.

---
 rtl/cvxif_copro_router_if.sv | 82 ++++++++
 rtl/cvxif_copro_router.sv | 244 ++++++++++++++++++++++++
 tb/tb_cvxif_copro_router.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvxif_copro_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_copro_router_if
//  Description : Bundle of the core-side CV-X-IF issue/commit/result signals
//                and the per-coprocessor fan-out/fan-in signals used by
//                cvxif_copro_router. Signal suffixes (_i/_o) are named from
//                the router's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cvxif_copro_router_if #(
  parameter int NrCopro    = 2,
  parameter int IdWidth    = 3,
  parameter int XLEN       = 64,
  parameter int InstrWidth = 32
);
  // Core issue channel
  logic                                issue_valid_i;
  logic                                issue_ready_o;
  logic [InstrWidth-1:0]               issue_instr_i;
  logic [2*XLEN-1:0]                   issue_rs_i;
  logic [IdWidth-1:0]                  issue_id_i;
  logic                                issue_accept_o;
  logic                                issue_writeback_o;
  // Coprocessor issue fan-out
  logic [NrCopro-1:0]                  cp_issue_valid_o;
  logic [NrCopro-1:0]                  cp_issue_ready_i;
  logic [NrCopro-1:0]                  cp_issue_accept_i;
  logic [NrCopro-1:0]                  cp_issue_writeback_i;
  logic [InstrWidth-1:0]               cp_issue_instr_o;
  logic [2*XLEN-1:0]                   cp_issue_rs_o;
  logic [IdWidth-1:0]                  cp_issue_id_o;
  // Commit channel
  logic                                commit_valid_i;
  logic [IdWidth-1:0]                  commit_id_i;
  logic                                commit_kill_i;
  logic [NrCopro-1:0]                  cp_commit_valid_o;
  logic [IdWidth-1:0]                  cp_commit_id_o;
  logic                                cp_commit_kill_o;
  // Coprocessor result fan-in
  logic [NrCopro-1:0]                  cp_result_valid_i;
  logic [NrCopro-1:0]                  cp_result_ready_o;
  logic [NrCopro-1:0][IdWidth-1:0]     cp_result_id_i;
  logic [NrCopro-1:0][4:0]             cp_result_rd_i;
  logic [NrCopro-1:0]                  cp_result_we_i;
  logic [NrCopro-1:0][XLEN-1:0]        cp_result_data_i;
  // Merged result to the core
  logic                                result_valid_o;
  logic                                result_ready_i;
  logic [IdWidth-1:0]                  result_id_o;
  logic [4:0]                          result_rd_o;
  logic                                result_we_o;
  logic [XLEN-1:0]                     result_data_o;

  // Router view
  modport slave (
    input  issue_valid_i, issue_instr_i, issue_rs_i, issue_id_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output cp_issue_valid_o, cp_issue_instr_o, cp_issue_rs_o, cp_issue_id_o,
    input  cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o,
    input  cp_result_valid_i, cp_result_id_i, cp_result_rd_i, cp_result_we_i, cp_result_data_i,
    output cp_result_ready_o,
    output result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
    input  result_ready_i
  );

  // Core + coprocessor view
  modport master (
    output issue_valid_i, issue_instr_i, issue_rs_i, issue_id_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  cp_issue_valid_o, cp_issue_instr_o, cp_issue_rs_o, cp_issue_id_o,
    output cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o,
    output cp_result_valid_i, cp_result_id_i, cp_result_rd_i, cp_result_we_i, cp_result_data_i,
    input  cp_result_ready_o,
    input  result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
    output result_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/cvxif_copro_router.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_copro_router
//  Description : CV-X-IF fabric between one core and up to four coprocessors.
//                Issues are steered by custom opcode, an ID ownership table
//                routes commits to the accepting coprocessor, and results are
//                merged by a round-robin arbiter into a registered output.
//                Optional macro CVXIF_ROUTER_PERF_EN builds the saturating
//                reject/stall performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cvxif_copro_router #(
  parameter int NrCopro    = 2,
  parameter int IdWidth    = 3,
  parameter int XLEN       = 64,
  parameter int InstrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cvxif_copro_router_if.slave  bus,
  output logic [IdWidth:0]     inflight_cnt_o,
  output logic [15:0]          perf_reject_o,
  output logic [15:0]          perf_stall_o
);
  localparam int Depth = 2 ** IdWidth;
  localparam int CntW  = IdWidth + 1;

  // Ownership table and result output stage
  logic [Depth-1:0]        valid_q, valid_d;
  logic [Depth-1:0][1:0]   owner_q, owner_d;
  logic [1:0]              ptr_q, ptr_d;
  logic                    res_valid_q, res_valid_d;
  logic [IdWidth-1:0]      res_id_q, res_id_d;
  logic [4:0]              res_rd_q, res_rd_d;
  logic                    res_we_q, res_we_d;
  logic [XLEN-1:0]         res_data_q, res_data_d;

  // Issue steering
  logic       opc_mapped;
  logic [1:0] sel_idx;
  logic       local_reject;
  logic       sel_ready, sel_accept, sel_wb;
  logic       issue_fire;

  // Commit routing
  logic [1:0] commit_owner;
  logic       commit_hit;

  // Result arbitration
  logic       can_grant;
  logic       grant_vld;
  logic [1:0] grant_idx;
  int         scan_idx;
  logic [IdWidth-1:0] win_id;
  logic [4:0]         win_rd;
  logic               win_we;
  logic [XLEN-1:0]    win_data;

  // Decode the custom opcode into a coprocessor index
  always_comb begin
    opc_mapped = 1'b1;
    sel_idx    = 2'd0;
    case (bus.issue_instr_i[6:0])
      7'h0B:   sel_idx = 2'd0;
      7'h2B:   sel_idx = 2'd1;
      7'h5B:   sel_idx = 2'd2;
      7'h7B:   sel_idx = 2'd3;
      default: opc_mapped = 1'b0;
    endcase
  end

  // Issue handshake: forward to the selected coprocessor or reject locally
  always_comb begin
    sel_ready  = 1'b0;
    sel_accept = 1'b0;
    sel_wb     = 1'b0;
    bus.cp_issue_valid_o = '0;
    local_reject = !opc_mapped || !(int'(sel_idx) < NrCopro) || valid_q[bus.issue_id_i];
    for (int i = 0; i < NrCopro; i++) begin
      if (int'(sel_idx) == i) begin
        sel_ready  = bus.cp_issue_ready_i[i];
        sel_accept = bus.cp_issue_accept_i[i];
        sel_wb     = bus.cp_issue_writeback_i[i];
        bus.cp_issue_valid_o[i] = bus.issue_valid_i && !local_reject;
      end
    end
    bus.issue_ready_o     = local_reject || sel_ready;
    bus.issue_accept_o    = !local_reject && sel_accept;
    bus.issue_writeback_o = !local_reject && sel_wb;
    issue_fire = bus.issue_valid_i && !local_reject && sel_ready && sel_accept;
  end

  assign bus.cp_issue_instr_o = bus.issue_instr_i;
  assign bus.cp_issue_rs_o    = bus.issue_rs_i;
  assign bus.cp_issue_id_o    = bus.issue_id_i;
  assign bus.cp_commit_id_o   = bus.commit_id_i;
  assign bus.cp_commit_kill_o = bus.commit_kill_i;

  // Route commit/kill only to the coprocessor owning the ID
  always_comb begin
    commit_owner = owner_q[bus.commit_id_i];
    commit_hit   = bus.commit_valid_i && valid_q[bus.commit_id_i];
    bus.cp_commit_valid_o = '0;
    for (int i = 0; i < NrCopro; i++) begin
      bus.cp_commit_valid_o[i] = commit_hit && (int'(commit_owner) == i);
    end
  end

  // Round-robin pick among pending results, starting at the pointer
  always_comb begin
    can_grant = !res_valid_q || bus.result_ready_i;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = 0;
    for (int k = 0; k < NrCopro; k++) begin
      scan_idx = (int'(ptr_q) + k) % NrCopro;
      for (int i = 0; i < NrCopro; i++) begin
        if (i == scan_idx && !grant_vld && can_grant && bus.cp_result_valid_i[i]) begin
          grant_vld = 1'b1;
          grant_idx = 2'(i);
        end
      end
    end
  end

  // Select the winner's payload and drive the one-hot result ready
  always_comb begin
    win_id   = '0;
    win_rd   = '0;
    win_we   = 1'b0;
    win_data = '0;
    bus.cp_result_ready_o = '0;
    for (int i = 0; i < NrCopro; i++) begin
      if (int'(grant_idx) == i) begin
        win_id   = bus.cp_result_id_i[i];
        win_rd   = bus.cp_result_rd_i[i];
        win_we   = bus.cp_result_we_i[i];
        win_data = bus.cp_result_data_i[i];
        bus.cp_result_ready_o[i] = grant_vld;
      end
    end
  end

  // Next state: result/kill clears first so a same-cycle issue set wins
  always_comb begin
    valid_d     = valid_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q && !bus.result_ready_i;
    res_id_d    = res_id_q;
    res_rd_d    = res_rd_q;
    res_we_d    = res_we_q;
    res_data_d  = res_data_q;
    if (grant_vld) begin
      res_valid_d       = 1'b1;
      res_id_d          = win_id;
      res_rd_d          = win_rd;
      res_we_d          = win_we;
      res_data_d        = win_data;
      valid_d[win_id]   = 1'b0;
      ptr_d             = (int'(grant_idx) == NrCopro - 1) ? 2'd0 : grant_idx + 2'd1;
    end
    if (bus.commit_valid_i && bus.commit_kill_i) begin
      valid_d[bus.commit_id_i] = 1'b0;
    end
    if (issue_fire) begin
      valid_d[bus.issue_id_i] = 1'b1;
      owner_d[bus.issue_id_i] = sel_idx;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= 2'd0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rd_q    <= '0;
      res_we_q    <= 1'b0;
      res_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rd_q    <= res_rd_d;
      res_we_q    <= res_we_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.result_valid_o = res_valid_q;
  assign bus.result_id_o    = res_id_q;
  assign bus.result_rd_o    = res_rd_q;
  assign bus.result_we_o    = res_we_q;
  assign bus.result_data_o  = res_data_q;

  // In-flight count is the population of the table
  always_comb begin
    inflight_cnt_o = '0;
    for (int j = 0; j < Depth; j++) begin
      inflight_cnt_o = inflight_cnt_o + CntW'(valid_q[j]);
    end
  end

`ifdef CVXIF_ROUTER_PERF_EN
  logic [15:0] rej_cnt_q, rej_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters for local rejects and back-pressured result cycles
  always_comb begin
    rej_cnt_d   = rej_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.issue_valid_i && local_reject && rej_cnt_q != 16'hFFFF) begin
      rej_cnt_d = rej_cnt_q + 16'd1;
    end
    if (res_valid_q && !bus.result_ready_i && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rej_cnt_q   <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      rej_cnt_q   <= rej_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_reject_o = rej_cnt_q;
  assign perf_stall_o  = stall_cnt_q;
`else
  assign perf_reject_o = 16'd0;
  assign perf_stall_o  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cvxif_copro_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cvxif_copro_router
//  Description : Self-checking bench for cvxif_copro_router: directed
//                scenarios with literal expectations followed by random
//                traffic, all checked every cycle against a behavioural model
//                of the ID table, round-robin arbiter and output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_copro_router;
  localparam int NR = 2;
  localparam int IW = 3;
  localparam int XL = 64;
  localparam int INW = 32;
`ifdef CVXIF_ROUTER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IW:0] inflight_cnt;
  logic [15:0] perf_reject, perf_stall;

  cvxif_copro_router_if #(.NrCopro(NR), .IdWidth(IW), .XLEN(XL), .InstrWidth(INW)) bus ();

  cvxif_copro_router #(.NrCopro(NR), .IdWidth(IW), .XLEN(XL), .InstrWidth(INW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus.slave),
    .inflight_cnt_o (inflight_cnt),
    .perf_reject_o  (perf_reject),
    .perf_stall_o   (perf_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_valid [8];
  int          m_owner [8];
  int          m_ptr;
  bit          m_ov;
  logic [IW-1:0] m_oid;
  logic [4:0]  m_ord;
  logic        m_owe;
  logic [63:0] m_odata;
  int          m_rej, m_stall;

  // Expected combinational values for the current cycle
  bit          e_reject, e_fire, e_ready, e_accept, e_wb;
  int          e_sel, e_win;
  logic [1:0]  e_cpv, e_commit, e_rr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_owner[i] = 0; end
    m_ptr = 0; m_ov = 0; m_oid = '0; m_ord = '0; m_owe = 0; m_odata = '0;
    m_rej = 0; m_stall = 0;
  endtask

  task automatic idle();
    bus.issue_valid_i = 0; bus.issue_instr_i = '0; bus.issue_rs_i = '0; bus.issue_id_i = '0;
    bus.cp_issue_ready_i = '0; bus.cp_issue_accept_i = '0; bus.cp_issue_writeback_i = '0;
    bus.commit_valid_i = 0; bus.commit_id_i = '0; bus.commit_kill_i = 0;
    bus.cp_result_valid_i = '0; bus.cp_result_id_i = '0; bus.cp_result_rd_i = '0;
    bus.cp_result_we_i = '0; bus.cp_result_data_i = '0; bus.result_ready_i = 0;
  endtask

  task automatic issue(input logic [6:0] opc, input int id, input logic [1:0] rdy, input logic [1:0] acc);
    bus.issue_valid_i = 1; bus.issue_instr_i = {25'h0, opc}; bus.issue_id_i = IW'(id);
    bus.cp_issue_ready_i = rdy; bus.cp_issue_accept_i = acc; bus.cp_issue_writeback_i = acc;
  endtask

  // Expected outputs from the spec rules
  task automatic model_comb();
    bit mapped;
    int cnt;
    mapped = 1; e_sel = 0;
    case (bus.issue_instr_i[6:0])
      7'h0B: e_sel = 0;
      7'h2B: e_sel = 1;
      7'h5B: e_sel = 2;
      7'h7B: e_sel = 3;
      default: mapped = 0;
    endcase
    e_reject = !mapped || e_sel >= NR || m_valid[bus.issue_id_i];
    if (e_reject) begin
      e_ready = 1; e_accept = 0; e_wb = 0; e_cpv = 2'b00;
    end else begin
      e_ready  = bus.cp_issue_ready_i[e_sel];
      e_accept = bus.cp_issue_accept_i[e_sel];
      e_wb     = bus.cp_issue_writeback_i[e_sel];
      e_cpv    = bus.issue_valid_i ? 2'(1 << e_sel) : 2'b00;
    end
    e_fire   = bus.issue_valid_i && !e_reject && e_ready && e_accept;
    e_commit = (bus.commit_valid_i && m_valid[bus.commit_id_i]) ? 2'(1 << m_owner[bus.commit_id_i]) : 2'b00;
    e_win = -1;
    if (!m_ov || bus.result_ready_i) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (e_win < 0 && bus.cp_result_valid_i[j]) e_win = j;
      end
    end
    e_rr = (e_win >= 0) ? 2'(1 << e_win) : 2'b00;
    chk("issue_ready", bus.issue_ready_o, e_ready);
    chk("issue_accept", bus.issue_accept_o, e_accept);
    chk("issue_wb", bus.issue_writeback_o, e_wb);
    chk("cp_issue_valid", bus.cp_issue_valid_o, e_cpv);
    chk("cp_commit_valid", bus.cp_commit_valid_o, e_commit);
    chk("cp_result_ready", bus.cp_result_ready_o, e_rr);
    chk("result_valid", bus.result_valid_o, m_ov);
    if (m_ov) begin
      chk("result_id", bus.result_id_o, m_oid);
      chk("result_rd", bus.result_rd_o, m_ord);
      chk("result_we", bus.result_we_o, m_owe);
      chk("result_data", bus.result_data_o, m_odata);
    end
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += m_valid[i];
    chk("inflight", inflight_cnt, cnt);
    chk("perf_reject", perf_reject, m_rej);
    chk("perf_stall", perf_stall, m_stall);
  endtask

  // Advance the model across one clock edge (clears first, set wins)
  task automatic model_seq();
    bit old_ov;
    old_ov = m_ov;
    if (m_ov && bus.result_ready_i) m_ov = 0;
    if (e_win >= 0) begin
      m_ov = 1;
      m_oid = bus.cp_result_id_i[e_win];
      m_ord = bus.cp_result_rd_i[e_win];
      m_owe = bus.cp_result_we_i[e_win];
      m_odata = bus.cp_result_data_i[e_win];
      m_valid[m_oid] = 0;
      m_ptr = (e_win + 1) % NR;
    end
    if (bus.commit_valid_i && bus.commit_kill_i) m_valid[bus.commit_id_i] = 0;
    if (e_fire) begin
      m_valid[bus.issue_id_i] = 1;
      m_owner[bus.issue_id_i] = e_sel;
    end
    if (PERF) begin
      if (bus.issue_valid_i && e_reject && m_rej < 65535) m_rej++;
      if (old_ov && !bus.result_ready_i && m_stall < 65535) m_stall++;
    end
  endtask

  task automatic cyc_begin();
    #3;
    model_comb();
  endtask

  task automatic cyc_end();
    model_seq();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    logic [6:0] opc;
    case ($urandom_range(0, 5))
      0: opc = 7'h0B;
      1: opc = 7'h2B;
      2: opc = 7'h0B;
      3: opc = 7'h2B;
      4: opc = 7'h5B;
      default: opc = 7'($urandom());
    endcase
    bus.issue_valid_i = ($urandom_range(0, 99) < 60);
    bus.issue_instr_i = {25'($urandom()), opc};
    bus.issue_rs_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.issue_id_i = IW'($urandom());
    bus.cp_issue_ready_i = 2'($urandom());
    bus.cp_issue_accept_i = 2'($urandom());
    bus.cp_issue_writeback_i = 2'($urandom());
    bus.commit_valid_i = ($urandom_range(0, 99) < 30);
    bus.commit_id_i = IW'($urandom());
    bus.commit_kill_i = 1'($urandom());
    for (int i = 0; i < NR; i++) begin
      bus.cp_result_valid_i[i] = ($urandom_range(0, 99) < 35);
      bus.cp_result_id_i[i] = IW'($urandom());
      bus.cp_result_rd_i[i] = 5'($urandom());
      bus.cp_result_we_i[i] = 1'($urandom());
      bus.cp_result_data_i[i] = {$urandom(), $urandom()};
    end
    bus.result_ready_i = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    cyc_begin();
    chk("rst_result_valid", bus.result_valid_o, 1'b0);
    chk("rst_result_data", bus.result_data_o, 64'h0);
    chk("rst_inflight", inflight_cnt, 0);
    chk("rst_perf_reject", perf_reject, 0);
    cyc_end();

    // Issue to copro1, then commit to its owner
    issue(7'h2B, 3, 2'b11, 2'b10);
    cyc_begin();
    chk("iss1_cpv", bus.cp_issue_valid_o, 2'b10);
    chk("iss1_accept", bus.issue_accept_o, 1'b1);
    cyc_end();
    idle(); bus.commit_valid_i = 1; bus.commit_id_i = 3'd3;
    cyc_begin();
    chk("iss1_inflight", inflight_cnt, 1);
    chk("commit1_cpv", bus.cp_commit_valid_o, 2'b10);
    cyc_end();

    // Opcode mapped to a coprocessor that does not exist
    idle(); issue(7'h5B, 4, 2'b11, 2'b11);
    cyc_begin();
    chk("unmapped_ready", bus.issue_ready_o, 1'b1);
    chk("unmapped_accept", bus.issue_accept_o, 1'b0);
    chk("unmapped_cpv", bus.cp_issue_valid_o, 2'b00);
    cyc_end();
    idle();
    cyc_begin();
    chk("unmapped_perf", perf_reject, PERF ? 1 : 0);
    cyc_end();

    // Collision, kill, re-issue
    issue(7'h2B, 3, 2'b11, 2'b11);
    cyc_begin();
    chk("collide_accept", bus.issue_accept_o, 1'b0);
    chk("collide_cpv", bus.cp_issue_valid_o, 2'b00);
    cyc_end();
    idle(); bus.commit_valid_i = 1; bus.commit_id_i = 3'd3; bus.commit_kill_i = 1;
    cyc_begin();
    cyc_end();
    idle(); issue(7'h2B, 3, 2'b11, 2'b11);
    cyc_begin();
    chk("reissue_cpv", bus.cp_issue_valid_o, 2'b10);
    chk("reissue_accept", bus.issue_accept_o, 1'b1);
    cyc_end();
    idle(); issue(7'h0B, 0, 2'b11, 2'b11);
    cyc_begin();
    cyc_end();

    // Both coprocessors hold results: grants alternate 0,1,0,1
    idle();
    bus.cp_result_valid_i = 2'b11;
    bus.cp_result_id_i[0] = 3'd0; bus.cp_result_id_i[1] = 3'd3;
    bus.cp_result_data_i[0] = 64'hAAAA; bus.cp_result_data_i[1] = 64'hBBBB;
    bus.result_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      cyc_begin();
      chk("rr_grant", bus.cp_result_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("rr_data", bus.result_data_o, (k % 2 == 1) ? 64'hAAAA : 64'hBBBB);
      if (k == 2) chk("rr_inflight", inflight_cnt, 0);
      cyc_end();
    end
    idle(); bus.result_ready_i = 1;
    cyc_begin();
    cyc_end();

    // Back-pressure for five cycles with another result pending
    idle();
    bus.cp_result_valid_i = 2'b01; bus.cp_result_id_i[0] = 3'd5;
    bus.cp_result_data_i[0] = 64'h1234;
    cyc_begin();
    cyc_end();
    idle(); bus.cp_result_valid_i = 2'b10; bus.cp_result_data_i[1] = 64'h5678;
    for (int k = 0; k < 5; k++) begin
      cyc_begin();
      chk("stall_data", bus.result_data_o, 64'h1234);
      chk("stall_ready", bus.cp_result_ready_o, 2'b00);
      cyc_end();
    end
    bus.result_ready_i = 1;
    cyc_begin();
    chk("stall_perf", perf_stall, PERF ? 5 : 0);
    chk("stall_release", bus.cp_result_ready_o, 2'b10);
    cyc_end();
    idle(); bus.result_ready_i = 1;
    cyc_begin();
    cyc_end();

    // Fill the table, then every issue collides
    for (int i = 0; i < 8; i++) begin
      idle(); issue(7'h0B, i, 2'b01, 2'b01);
      cyc_begin();
      cyc_end();
    end
    idle(); issue(7'h2B, 5, 2'b11, 2'b11);
    cyc_begin();
    chk("full_inflight", inflight_cnt, 8);
    chk("full_accept", bus.issue_accept_o, 1'b0);
    cyc_end();
    for (int i = 0; i < 8; i++) begin
      idle(); bus.commit_valid_i = 1; bus.commit_kill_i = 1; bus.commit_id_i = IW'(i);
      cyc_begin();
      cyc_end();
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      cyc_begin();
      cyc_end();
    end

    // Asynchronous reset with entries in flight and a result held
    idle(); bus.result_ready_i = 1;
    cyc_begin(); cyc_end();
    for (int i = 0; i < 8; i++) begin
      idle(); bus.commit_valid_i = 1; bus.commit_kill_i = 1; bus.commit_id_i = IW'(i);
      cyc_begin(); cyc_end();
    end
    idle(); issue(7'h0B, 1, 2'b11, 2'b11);
    cyc_begin(); cyc_end();
    idle(); issue(7'h2B, 2, 2'b11, 2'b11);
    cyc_begin(); cyc_end();
    idle(); bus.cp_result_valid_i = 2'b01; bus.cp_result_id_i[0] = 3'd6;
    bus.cp_result_data_i[0] = 64'hDEAD;
    cyc_begin(); cyc_end();
    idle();
    cyc_begin();
    chk("pre_rst_inflight", inflight_cnt, 2);
    chk("pre_rst_valid", bus.result_valid_o, 1'b1);
    rst = 1;
    #1;
    chk("arst_result_valid", bus.result_valid_o, 1'b0);
    chk("arst_result_data", bus.result_data_o, 64'h0);
    chk("arst_inflight", inflight_cnt, 0);
    chk("arst_cpv", bus.cp_issue_valid_o, 2'b00);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    cyc_begin();
    cyc_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
